// File: rtl/black_input_cond.sv
// Purpose: synchronise and debounce the push keys and the start switch ahead of the game core,
//          turning each qualified key press into exactly one single-cycle pulse.
// Latency: key_pulse appears DEBOUNCE_CYCLES+4 edges after a clean press; start_level DEBOUNCE_CYCLES+2.
// Backpressure: enable = 0 drops every pending press; with enable = 1 one press is issued per
//               cycle, lowest key index first, and later presses wait in their pending bits.
//
// Ports:
//   clk          system clock, single domain
//   reset_n      asynchronous active-low reset
//   key_n        raw push keys, active-low, asynchronous (0 = hit, 1 = pass)
//   sw_start     raw start switch, active-high, asynchronous
//   enable       game core can accept an action this cycle
//   key_pulse    one-cycle press strobe, at most one bit set
//   key_level    debounced held state per key
//   start_level  debounced start switch level
module black_input_cond #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    input  logic              sw_start,
    input  logic              enable,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] key_level,
    output logic              start_level
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers. Keys reset to the released level (1) so a
    // key held through reset is seen as a fresh press once reset lifts.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] key_meta;
    logic [N_KEYS-1:0] key_sync;
    logic              st_meta;
    logic              st_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= '1;
            key_sync <= '1;
            st_meta  <= 1'b0;
            st_sync  <= 1'b0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            st_meta  <= sw_start;
            st_sync  <= st_meta;
        end
    end

    // ------------------------------------------------------------------
    // Per-key debounce FSMs
    // ------------------------------------------------------------------
    key_state_t        state_q [N_KEYS];
    key_state_t        state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];
    logic [N_KEYS-1:0] press_set;
    logic [N_KEYS-1:0] level_d;

    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            press_set[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (!key_sync[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (key_sync[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = HELD;
                        press_set[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (key_sync[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back low during release is the same press, not a new one.
                    if (!key_sync[i]) begin
                        state_d[i] = HELD;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            // Level tracks the state being entered, so it rises on the same edge as HELD.
            level_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_WAIT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            key_level <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            key_level <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Pending-press arbiter: one pulse per cycle, lowest index wins.
    // Repeated presses of a key whose bit is still set merge into it.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] pending_q;
    logic [N_KEYS-1:0] grant;

    // Two's-complement trick isolates the lowest set bit.
    assign grant = pending_q & (~pending_q + N_KEYS'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            key_pulse <= '0;
        end else if (enable) begin
            key_pulse <= grant;
            pending_q <= (pending_q & ~grant) | press_set;
        end else begin
            // Core not ready: drop everything, including presses qualifying this cycle.
            key_pulse <= '0;
            pending_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Start switch: symmetric filter, level flips only after the synced
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] st_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_level <= 1'b0;
            st_cnt_q    <= '0;
        end else if (st_sync != start_level) begin
            if (st_cnt_q == CNT_LAST) begin
                start_level <= st_sync;
                st_cnt_q    <= '0;
            end else begin
                st_cnt_q <= st_cnt_q + CNT_W'(1);
            end
        end else begin
            st_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_black_input_cond.sv
// Bench for black_input_cond with DEBOUNCE_CYCLES = 4. Stimulus pushes expected
// pulses (value + edge number) into a scoreboard; a monitor on the falling edge pops
// and compares whenever key_pulse is non-zero. Levels are checked inline.
module tb_black_input_cond;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] key_n;
    logic       sw_start;
    logic       enable;
    logic [1:0] key_pulse;
    logic [1:0] key_level;
    logic       start_level;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0;

    logic [1:0] exp_val [$];
    int         exp_cyc [$];
    logic [1:0] mon_v;
    int         mon_c;

    black_input_cond #(
        .N_KEYS         (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_n      (key_n),
        .sw_start   (sw_start),
        .enable     (enable),
        .key_pulse  (key_pulse),
        .key_level  (key_level),
        .start_level(start_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] v, input int c);
        exp_val.push_back(v);
        exp_cyc.push_back(c);
    endtask

    // Monitor: every observed pulse must match the next scoreboard entry in value and edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && key_pulse !== 2'b00) begin
            if (exp_val.size() == 0) begin
                chk("unexpected_pulse", {30'b0, key_pulse}, 32'h0);
            end else begin
                mon_v = exp_val.pop_front();
                mon_c = exp_cyc.pop_front();
                chk("pulse_value", {30'b0, key_pulse}, {30'b0, mon_v});
                chk("pulse_edge", cyc, mon_c);
            end
        end
    end

    initial begin
        key_n    = 2'b11;
        sw_start = 1'b0;
        enable   = 1'b1;
        reset_n  = 1'b0;

        // Reset state
        step(3);
        chk("reset_pulse", {30'b0, key_pulse}, 32'h0);
        chk("reset_level", {30'b0, key_level}, 32'h0);
        chk("reset_start", {31'b0, start_level}, 32'h0);
        reset_n = 1'b1;
        step(2);

        // 1: single hit press held 20 cycles
        t0 = cyc;
        key_n = 2'b10;
        push(2'b01, t0 + 8);
        step(6);
        chk("t1_level_e6", {30'b0, key_level}, 32'h0);
        step(1);
        chk("t1_level_e7", {30'b0, key_level}, 32'h1);
        step(13);
        key_n = 2'b11;
        step(12);
        chk("t1_level_released", {30'b0, key_level}, 32'h0);
        chk("t1_drained", exp_val.size(), 32'h0);

        // 2: short 3-cycle glitches on pass key are rejected
        repeat (5) begin
            key_n = 2'b01;
            step(3);
            chk("t2_level", {30'b0, key_level}, 32'h0);
            key_n = 2'b11;
            step(3);
        end
        step(8);
        chk("t2_level_end", {30'b0, key_level}, 32'h0);

        // 3: both keys at once -> hit first, pass next cycle
        t0 = cyc;
        key_n = 2'b00;
        push(2'b01, t0 + 8);
        push(2'b10, t0 + 9);
        step(12);
        chk("t3_level", {30'b0, key_level}, 32'h3);
        key_n = 2'b11;
        step(12);
        chk("t3_drained", exp_val.size(), 32'h0);

        // 4: enable low through qualification -> press dropped, level still held
        enable = 1'b0;
        key_n  = 2'b10;
        step(12);
        enable = 1'b1;
        step(5);
        chk("t4_level", {30'b0, key_level}, 32'h1);
        key_n = 2'b11;
        step(12);
        chk("t4_level_released", {30'b0, key_level}, 32'h0);
        chk("t4_drained", exp_val.size(), 32'h0);

        // 5: release with a 2-cycle re-press bounce -> back to HELD, single pulse
        t0 = cyc;
        key_n = 2'b10;
        push(2'b01, t0 + 8);
        step(12);
        key_n = 2'b11;
        step(3);
        key_n = 2'b10;
        step(2);
        key_n = 2'b11;
        step(2);
        chk("t5_level_bounce", {30'b0, key_level}, 32'h1);
        step(14);
        chk("t5_level_released", {30'b0, key_level}, 32'h0);
        chk("t5_drained", exp_val.size(), 32'h0);

        // Start switch: 3-cycle excursion ignored, held level accepted after 2 + 4 edges
        sw_start = 1'b1;
        step(3);
        sw_start = 1'b0;
        step(8);
        chk("start_glitch", {31'b0, start_level}, 32'h0);
        sw_start = 1'b1;
        step(5);
        chk("start_e5", {31'b0, start_level}, 32'h0);
        step(1);
        chk("start_e6", {31'b0, start_level}, 32'h1);
        step(4);

        // 6: reset during PRESS_WAIT with key held -> fresh press after release
        key_n = 2'b10;
        step(4);
        reset_n = 1'b0;
        #1;
        chk("t6_reset_pulse", {30'b0, key_pulse}, 32'h0);
        chk("t6_reset_level", {30'b0, key_level}, 32'h0);
        chk("t6_reset_start", {31'b0, start_level}, 32'h0);
        step(2);
        reset_n = 1'b1;
        t0 = cyc;
        push(2'b01, t0 + 8);
        step(5);
        chk("t6_start_e5", {31'b0, start_level}, 32'h0);
        step(1);
        chk("t6_start_e6", {31'b0, start_level}, 32'h1);
        step(6);
        chk("t6_level", {30'b0, key_level}, 32'h1);
        key_n = 2'b11;
        step(12);
        chk("t6_level_released", {30'b0, key_level}, 32'h0);
        chk("t6_drained", exp_val.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
